arbiter_pkt_wrr: RTL and testbench
==================================

ARBITER_PKT_WRR -- requirements
Module: arbiter_pkt_wrr

Interface
REQ-001 Parameters (name, default, meaning):
- CHANNEL_NUMBER, 5, number of input streams (2..16)
- DATA_WIDTH, 32, TDATA width
- ID_WIDTH, 4, TID width
- ROUTING_HEADER, 0, TID value marking a header beat
- MAX_ROUTERS_X, 4, mesh X size; XW = $clog2(MAX_ROUTERS_X)
- MAX_ROUTERS_Y, 4, mesh Y size; YW = $clog2(MAX_ROUTERS_Y)
- LEN_WIDTH, 8, packet length field width
- WEIGHT_WIDTH, 4, per-channel weight width
- WEIGHTS, all 1, packed CHANNEL_NUMBER*WEIGHT_WIDTH weights; channel i at [i*WEIGHT_WIDTH +: WEIGHT_WIDTH]

REQ-002 Ports (name, direction, width, meaning):
- clk, in, 1, single clock; all logic on rising edge
- rst, in, 1, synchronous, active-high reset
- in_tvalid, in, CHANNEL_NUMBER, per-channel valid
- in_tready, out, CHANNEL_NUMBER, per-channel ready
- in_tdata, in, CHANNEL_NUMBER*DATA_WIDTH, packed data
- in_tid, in, CHANNEL_NUMBER*ID_WIDTH, packed ID
- out_tvalid, out, 1; out_tready, in, 1; out_tdata, out, DATA_WIDTH; out_tid, out, ID_WIDTH
- current_grant, out, $clog2(CHANNEL_NUMBER), granted channel
- locked, out, 1, packet in progress
- target_x, out, XW; target_y, out, YW, destination of current packet

Function
REQ-003 Header fields: target_y = TDATA[YW-1:0]; target_x = TDATA[XW+YW-1:YW]; len = TDATA[2*(XW+YW) +: LEN_WIDTH] = payload beats after header.
REQ-004 FSM states IDLE, LOCKED; reset -> IDLE.
REQ-005 IDLE: in_tready = 0, out_tvalid = 0; if any in_tvalid, register current_grant = first valid channel searching from last_grant+1 upward, wrapping modulo CHANNEL_NUMBER; go LOCKED next cycle (1-cycle arbitration latency).
REQ-006 LOCKED: out_* = input[current_grant]; in_tready[current_grant] = out_tready; other in_tready = 0; no combinational path from out_tready to the grant decision.
REQ-007 First transfer in LOCKED with TID == ROUTING_HEADER loads remaining = len and registers target_x/target_y; same cycle target_x/target_y are driven combinationally from out_tdata.
REQ-008 First transfer with TID != ROUTING_HEADER is treated as a single-beat packet (len = 0).
REQ-009 Each later transfer (out_tvalid & out_tready) decrements remaining; packet ends on the transfer that makes remaining 0, or on the header transfer itself when len = 0.
REQ-010 At packet end: last_grant <= current_grant; FSM -> IDLE, unless REQ-016 holds the grant.
REQ-011 Grant never changes mid-packet, even if the granted in_tvalid drops; stalls (out_tready = 0) hold all state.
REQ-012 locked = 1 exactly in LOCKED; target_x/target_y hold their last registered values outside the header beat.
REQ-013 remaining is LEN_WIDTH bits; len = 2^LEN_WIDTH-1 is legal; no wrap below 0.

Reset
REQ-014 rst high at a clock edge: state = IDLE, current_grant = 0, last_grant = CHANNEL_NUMBER-1 (channel 0 wins first), remaining = 0, target_x = 0, target_y = 0, out_tvalid = 0, in_tready = 0; any packet in progress is abandoned.
REQ-015 Reset is honoured in any state.

Configuration
REQ-016 ARB_WEIGHTED_EN defined: a per-grant packet counter tracks packets sent since the channel won the grant; at packet end, if count+1 < WEIGHTS[current_grant] and in_tvalid[current_grant] = 1, the FSM stays LOCKED on the same channel (no IDLE cycle) and the counter increments; otherwise the counter clears and REQ-010 applies. A weight of 0 is treated as 1.
REQ-017 ARB_WEIGHTED_EN undefined: WEIGHTS is ignored and each grant carries exactly one packet.

Verification
REQ-018 After reset, channels 0 and 3 each offer a header with len = 2 -> channel 0 sends 3 beats, 1 IDLE cycle, then channel 3 sends 3 beats; current_grant = 0 then 3.
REQ-019 All 5 channels continuously valid, len = 0 -> grant order 0,1,2,3,4,0; each channel gets 1 beat per 10 cycles.
REQ-020 Channel 2 granted with len = 4, out_tready toggles 1/0 and in_tvalid[2] drops for 3 cycles mid-packet -> grant stays 2; exactly 5 transfers; no other channel ready.
REQ-021 Header TDATA = {len = 1, x = 2, y = 3} -> target_x = 2 and target_y = 3 in the header cycle and held to packet end.
REQ-022 rst asserted during the 2nd beat of a len = 5 packet -> next cycle state IDLE, all outputs at reset values; channel 0 is granted first afterwards.
REQ-023 ARB_WEIGHTED_EN defined, WEIGHTS ch0 = 3, others = 1, all channels valid, len = 0 -> order 0,0,0,1,2,3,4,0,0,0; no IDLE cycle between the back-to-back ch0 packets.

Source files
------------

// File: rtl/arbiter_pkt_wrr.sv
// arbiter_pkt_wrr
// Packet-aware round-robin arbiter for a mesh router. It merges CHANNEL_NUMBER
// AXI-Stream-like inputs onto one output. Once a channel wins the grant, it keeps
// the grant for a whole packet. The packet length comes from the header beat
// (TID == ROUTING_HEADER). A beat whose first TID is not a header counts as a
// single-beat packet.
//
// Optional feature: define ARB_WEIGHTED_EN to let a channel send up to
// WEIGHTS[ch] back-to-back packets per grant. A weight of 0 behaves as 1.
//
// Ports:
//   clk, rst         - single rising-edge clock, synchronous active-high reset
//   in_tvalid/tready - per-channel handshake (CHANNEL_NUMBER bits each)
//   in_tdata/in_tid  - packed per-channel data / ID
//   out_tvalid/tready/tdata/tid - merged output stream
//   current_grant    - channel currently owning the output
//   locked           - high while a packet is in progress
//   target_x/y       - destination of the current packet (from its header)
module arbiter_pkt_wrr #(
  parameter int CHANNEL_NUMBER = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int ID_WIDTH       = 4,
  parameter int ROUTING_HEADER = 0,
  parameter int MAX_ROUTERS_X  = 4,
  parameter int MAX_ROUTERS_Y  = 4,
  parameter int LEN_WIDTH      = 8,
  parameter int WEIGHT_WIDTH   = 4,
  parameter logic [CHANNEL_NUMBER*WEIGHT_WIDTH-1:0] WEIGHTS =
    {CHANNEL_NUMBER{WEIGHT_WIDTH'(1)}}
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [CHANNEL_NUMBER-1:0]             in_tvalid,
  output logic [CHANNEL_NUMBER-1:0]             in_tready,
  input  logic [CHANNEL_NUMBER*DATA_WIDTH-1:0]  in_tdata,
  input  logic [CHANNEL_NUMBER*ID_WIDTH-1:0]    in_tid,
  output logic                                  out_tvalid,
  input  logic                                  out_tready,
  output logic [DATA_WIDTH-1:0]                 out_tdata,
  output logic [ID_WIDTH-1:0]                   out_tid,
  output logic [$clog2(CHANNEL_NUMBER)-1:0]     current_grant,
  output logic                                  locked,
  output logic [$clog2(MAX_ROUTERS_X)-1:0]      target_x,
  output logic [$clog2(MAX_ROUTERS_Y)-1:0]      target_y
);

  localparam int XW      = $clog2(MAX_ROUTERS_X);
  localparam int YW      = $clog2(MAX_ROUTERS_Y);
  localparam int GW      = $clog2(CHANNEL_NUMBER);
  localparam int LEN_LSB = 2 * (XW + YW);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        grant_q, grant_d;
  logic [GW-1:0]        last_grant_q, last_grant_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic                 first_q, first_d;
  logic [XW-1:0]        tx_q, tx_d;
  logic [YW-1:0]        ty_q, ty_d;
`ifdef ARB_WEIGHTED_EN
  logic [WEIGHT_WIDTH-1:0] cnt_q, cnt_d;
  logic [WEIGHT_WIDTH-1:0] weight_sel;
`endif

  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [ID_WIDTH-1:0]   sel_id;
  logic                  rr_found;
  logic [GW-1:0]         rr_pick;
  logic                  xfer;
  logic                  is_header;
  logic                  pkt_end;
  logic [LEN_WIDTH-1:0]  hdr_len;
  logic [XW-1:0]         hdr_x;
  logic [YW-1:0]         hdr_y;

  // Select the granted channel's stream. The output path depends only on
  // grant_q, so out_tready never feeds back into the arbitration decision.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_id    = '0;
`ifdef ARB_WEIGHTED_EN
    weight_sel = '0;
`endif
    for (int c = 0; c < CHANNEL_NUMBER; c++) begin
      if (grant_q == GW'(c)) begin
        sel_valid = in_tvalid[c];
        sel_data  = in_tdata[c*DATA_WIDTH +: DATA_WIDTH];
        sel_id    = in_tid[c*ID_WIDTH +: ID_WIDTH];
`ifdef ARB_WEIGHTED_EN
        weight_sel = WEIGHTS[c*WEIGHT_WIDTH +: WEIGHT_WIDTH];
`endif
      end
    end
  end

  // Round-robin search: the first valid channel after last_grant wins,
  // wrapping modulo CHANNEL_NUMBER.
  always_comb begin
    int            idx;
    logic [GW-1:0] idx_g;
    rr_found = 1'b0;
    rr_pick  = '0;
    idx      = 0;
    idx_g    = '0;
    for (int i = 1; i <= CHANNEL_NUMBER; i++) begin
      idx = int'(last_grant_q) + i;
      if (idx >= CHANNEL_NUMBER) idx = idx - CHANNEL_NUMBER;
      idx_g = GW'(idx);
      if (!rr_found && in_tvalid[idx_g]) begin
        rr_found = 1'b1;
        rr_pick  = idx_g;
      end
    end
  end

  assign hdr_len   = sel_data[LEN_LSB +: LEN_WIDTH];
  assign hdr_x     = sel_data[YW +: XW];
  assign hdr_y     = sel_data[0 +: YW];
  assign is_header = (sel_id == ID_WIDTH'(ROUTING_HEADER));
  assign xfer      = (state_q == LOCKED) && sel_valid && out_tready;

  // Next-state logic. The first transfer of a packet sets the beat count.
  // Each later transfer counts down. The packet ends on the last payload beat,
  // or on the first beat itself when there is no payload.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    remaining_d  = remaining_q;
    first_d      = first_q;
    tx_d         = tx_q;
    ty_d         = ty_q;
`ifdef ARB_WEIGHTED_EN
    cnt_d        = cnt_q;
`endif
    pkt_end      = 1'b0;
    out_tvalid   = 1'b0;
    in_tready    = '0;

    case (state_q)
      IDLE: begin
        if (rr_found) begin
          grant_d     = rr_pick;
          state_d     = LOCKED;
          first_d     = 1'b1;
          remaining_d = '0;
        end
      end
      LOCKED: begin
        out_tvalid = sel_valid;
        if (out_tready) in_tready[grant_q] = 1'b1;
        if (xfer) begin
          if (first_q) begin
            first_d = 1'b0;
            if (is_header) begin
              tx_d        = hdr_x;
              ty_d        = hdr_y;
              remaining_d = hdr_len;
              pkt_end     = (hdr_len == '0);
            end else begin
              remaining_d = '0;
              pkt_end     = 1'b1;
            end
          end else begin
            // remaining_q is at least 1 here. The guard stops the counter from
            // ever wrapping below zero.
            if (remaining_q != '0) remaining_d = remaining_q - LEN_WIDTH'(1);
            pkt_end = (remaining_q <= LEN_WIDTH'(1));
          end
          if (pkt_end) begin
            first_d = 1'b1;
`ifdef ARB_WEIGHTED_EN
            // Keep the grant for another packet while the channel has weight
            // left. Comparing against max(weight,1) makes weight 0 act as 1.
            if (({1'b0, cnt_q} + 1'b1) <
                ((weight_sel == '0) ? (WEIGHT_WIDTH+1)'(1) : {1'b0, weight_sel})
                && sel_valid) begin
              cnt_d = cnt_q + WEIGHT_WIDTH'(1);
            end else begin
              cnt_d        = '0;
              last_grant_d = grant_q;
              state_d      = IDLE;
            end
`else
            last_grant_d = grant_q;
            state_d      = IDLE;
`endif
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register. Reset abandons any packet in progress. last_grant starts
  // at the highest channel so that channel 0 wins the first arbitration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= '0;
      last_grant_q <= GW'(CHANNEL_NUMBER - 1);
      remaining_q  <= '0;
      first_q      <= 1'b1;
      tx_q         <= '0;
      ty_q         <= '0;
`ifdef ARB_WEIGHTED_EN
      cnt_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      remaining_q  <= remaining_d;
      first_q      <= first_d;
      tx_q         <= tx_d;
      ty_q         <= ty_d;
`ifdef ARB_WEIGHTED_EN
      cnt_q        <= cnt_d;
`endif
    end
  end

  assign out_tdata     = sel_data;
  assign out_tid       = sel_id;
  assign current_grant = grant_q;
  assign locked        = (state_q == LOCKED);

  // While a header beat is on the output, the destination comes straight from
  // its data. Otherwise the last registered destination is held.
  assign target_x = (locked && first_q && sel_valid && is_header) ? hdr_x : tx_q;
  assign target_y = (locked && first_q && sel_valid && is_header) ? hdr_y : ty_q;

endmodule

// File: tb/tb_arbiter_pkt_wrr.sv
// Randomized scoreboard bench for arbiter_pkt_wrr.
// The bench holds a queue of whole packets for each channel. A packet-level
// model decides which channel owns the output and which beat should go out.
// It pushes per-cycle expectations and expected transfers into queues. A
// separate monitor pops those queues and compares them with the DUT.
// With ARB_WEIGHTED_EN defined, the bench uses weights ch0=3, ch1=2, others 1.
module tb_arbiter_pkt_wrr;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam logic [N*4-1:0] WTS = 20'h11123;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    in_tvalid;
  logic [N-1:0]    in_tready;
  logic [N*DW-1:0] in_tdata;
  logic [N*IW-1:0] in_tid;
  logic            out_tvalid;
  logic            out_tready;
  logic [DW-1:0]   out_tdata;
  logic [IW-1:0]   out_tid;
  logic [2:0]      current_grant;
  logic            locked;
  logic [1:0]      target_x;
  logic [1:0]      target_y;

  arbiter_pkt_wrr #(
    .CHANNEL_NUMBER(N), .DATA_WIDTH(DW), .ID_WIDTH(IW), .ROUTING_HEADER(0),
    .MAX_ROUTERS_X(4), .MAX_ROUTERS_Y(4), .LEN_WIDTH(8), .WEIGHT_WIDTH(4),
    .WEIGHTS(WTS)
  ) dut (
    .clk(clk), .rst(rst),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_tdata(in_tdata), .in_tid(in_tid),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_tdata(out_tdata), .out_tid(out_tid),
    .current_grant(current_grant), .locked(locked),
    .target_x(target_x), .target_y(target_y)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] data; logic [3:0] tid; bit last; } beat_t;
  typedef struct { int grant; logic [31:0] data; logic [3:0] tid; int tx; int ty; } xfer_t;
  typedef struct { bit lck; bit tvalid; logic [N-1:0] tready; bit chk_rst; } cyc_t;

  beat_t chq[N][$];
  xfer_t sb[$];
  cyc_t  cq[$];

  int checks = 0;
  int failures = 0;
  int fail_prints = 0;
  int n_exp = 0;
  int n_seen = 0;
  int weight[N] = '{3, 2, 1, 1, 1};

  // Packet-level model state
  bit m_locked, m_mid, m_just_rst;
  int m_grant, m_last, m_tx, m_ty, m_cnt;
  logic [N-1:0] pv;
  bit pr, prst;
  int rst_hold = 0;

  // Compare one value and record any failure
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (fail_prints < 60) begin
        fail_prints++;
        $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
    end
  endtask

  // Queue one packet for a channel: a header with len payload beats, or a
  // single non-header beat
  task automatic addPacket(input int c, input int len, input bit single);
    beat_t b;
    if (single) begin
      b.data = $urandom; b.tid = 4'($urandom_range(1, 15)); b.last = 1'b1;
      chq[c].push_back(b);
    end else begin
      b.data = $urandom; b.data[15:8] = 8'(len); b.tid = 4'h0; b.last = (len == 0);
      chq[c].push_back(b);
      for (int k = 1; k <= len; k++) begin
        b.data = $urandom; b.tid = 4'($urandom_range(0, 15)); b.last = (k == len);
        chq[c].push_back(b);
      end
    end
  endtask

  function automatic int rrPick(input int last, input logic [N-1:0] v);
    for (int i = 1; i <= N; i++) begin
      if (v[(last + i) % N]) return (last + i) % N;
    end
    return 0;
  endfunction

  // Drive one cycle of inputs from the channel queues
  task automatic applyStimulus(input logic [N-1:0] v, input bit r, input bit rs);
    rst = rs;
    out_tready = r;
    in_tvalid = v;
    for (int c = 0; c < N; c++) begin
      if (chq[c].size() > 0) begin
        in_tdata[c*DW +: DW] = chq[c][0].data;
        in_tid[c*IW +: IW]   = chq[c][0].tid;
      end else begin
        in_tdata[c*DW +: DW] = '0;
        in_tid[c*IW +: IW]   = '0;
      end
    end
  endtask

  // Advance the model by what happened in the previous cycle
  task automatic modelStep();
    beat_t b;
    bit done;
    if (prst) begin
      if (m_locked && m_mid) begin
        done = 1'b0;
        while (!done && chq[m_grant].size() > 0) begin
          b = chq[m_grant].pop_front();
          done = b.last;
        end
      end
      m_locked = 0; m_mid = 0; m_grant = 0; m_last = N - 1;
      m_tx = 0; m_ty = 0; m_cnt = 0; m_just_rst = 1;
    end else begin
      m_just_rst = 0;
      if (!m_locked) begin
        if (pv != '0) begin
          m_grant = rrPick(m_last, pv);
          m_locked = 1; m_mid = 0;
        end
      end else if (pv[m_grant] && pr) begin
        b = chq[m_grant].pop_front();
        if (!m_mid && b.tid == 4'h0) begin
          m_tx = int'(b.data[3:2]); m_ty = int'(b.data[1:0]);
        end
        m_mid = !b.last;
        if (b.last) begin
`ifdef ARB_WEIGHTED_EN
          if (m_cnt + 1 < ((weight[m_grant] == 0) ? 1 : weight[m_grant])) begin
            m_cnt++;
          end else begin
            m_cnt = 0; m_locked = 0; m_last = m_grant;
          end
`else
          m_locked = 0; m_last = m_grant;
`endif
        end
      end
    end
  endtask

  // One bench cycle. mode 0: reset, 1: all valid with len 0,
  // 2: random traffic, 3: drain
  task automatic runCycle(input int mode);
    logic [N-1:0] v;
    bit r, rs;
    int len;
    cyc_t e;
    xfer_t x;
    @(posedge clk);
    #1;
    modelStep();
    rs = (mode == 0);
    if (mode == 2) begin
      if (rst_hold > 0) begin rs = 1; rst_hold--; end
      else if ($urandom_range(0, 299) == 0) begin rs = 1; rst_hold = 1; end
    end
    for (int c = 0; c < N; c++) begin
      if (mode == 1 && chq[c].size() == 0) addPacket(c, 0, 0);
      if (mode == 2 && chq[c].size() == 0 && $urandom_range(0, 3) != 0) begin
        len = $urandom_range(0, 4);
        addPacket(c, len, $urandom_range(0, 4) == 0);
      end
      v[c] = (chq[c].size() > 0) && (mode != 2 || $urandom_range(0, 3) != 0);
    end
    r = (mode == 2) ? ($urandom_range(0, 9) < 7) : 1'b1;
    if (rs) r = 1'b0;
    applyStimulus(v, r, rs);
    e.lck = m_locked;
    e.tvalid = m_locked && v[m_grant];
    e.tready = '0;
    if (m_locked && r) e.tready[m_grant] = 1'b1;
    e.chk_rst = m_just_rst;
    cq.push_back(e);
    if (e.tvalid && r) begin
      x.grant = m_grant;
      x.data = chq[m_grant][0].data;
      x.tid = chq[m_grant][0].tid;
      if (!m_mid && x.tid == 4'h0) begin
        x.tx = int'(x.data[3:2]); x.ty = int'(x.data[1:0]);
      end else begin
        x.tx = m_tx; x.ty = m_ty;
      end
      sb.push_back(x);
      n_exp++;
    end
    pv = v; pr = r; prst = rs;
  endtask

  // Monitor: check the per-cycle expectations and every transfer on the output
  initial begin
    cyc_t e;
    xfer_t x;
    forever begin
      @(negedge clk);
      if (cq.size() > 0) begin
        e = cq.pop_front();
        checkOutput("locked", 64'(locked), 64'(e.lck));
        checkOutput("out_tvalid", 64'(out_tvalid), 64'(e.tvalid));
        checkOutput("in_tready", 64'(in_tready), 64'(e.tready));
        if (e.chk_rst) begin
          checkOutput("rst_grant", 64'(current_grant), 64'd0);
          checkOutput("rst_target_x", 64'(target_x), 64'd0);
          checkOutput("rst_target_y", 64'(target_y), 64'd0);
        end
      end
      if (out_tvalid === 1'b1 && out_tready === 1'b1) begin
        n_seen++;
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("[TB] FAIL unexpected_xfer actual=1 required=0 at %0t", $time);
        end else begin
          x = sb.pop_front();
          checkOutput("grant", 64'(current_grant), 64'(x.grant));
          checkOutput("tdata", 64'(out_tdata), 64'(x.data));
          checkOutput("tid", 64'(out_tid), 64'(x.tid));
          checkOutput("target_x", 64'(target_x), 64'(x.tx));
          checkOutput("target_y", 64'(target_y), 64'(x.ty));
        end
      end
    end
  end

  initial begin
    bit empty;
    int budget;
    rst = 1'b1; out_tready = 1'b0; in_tvalid = '0; in_tdata = '0; in_tid = '0;
    prst = 1; pv = '0; pr = 0;
    m_locked = 0; m_mid = 0; m_grant = 0; m_last = N - 1; m_tx = 0; m_ty = 0; m_cnt = 0;
    for (int i = 0; i < 3; i++) runCycle(0);
    for (int i = 0; i < 150; i++) runCycle(1);
    addPacket(2, 255, 0);
    for (int i = 0; i < 2000; i++) runCycle(2);
    rst_hold = 0;
    budget = 0;
    empty = 0;
    while (!empty && budget < 5000) begin
      runCycle(3);
      budget++;
      empty = (sb.size() == 0) && !m_mid;
      for (int c = 0; c < N; c++) if (chq[c].size() > 0) empty = 0;
    end
    if (!empty) begin
      checks++; failures++;
      $display("[TB] FAIL drain_timeout actual=%0d required=0", sb.size());
    end
    runCycle(3);
    runCycle(3);
    @(negedge clk);
    #1;
    checkOutput("sb_empty", 64'(sb.size()), 64'd0);
    checkOutput("xfer_count", 64'(n_seen), 64'(n_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
